uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
// Serialising transmit half of the UART behind UART_IFace. Accepts a parallel word on
// Tx_Data/Transmit_Start and shifts it out on Tx as start, data (LSB first), optional
// even parity and stop bits at BAUD_RATE. Gated by CTS; reports Tx_Busy to the writer.
// PARAMETERS
// SYSCLK_RATE  100000000  SysClk frequency, Hz
// BAUD_RATE    9600       line bit rate, bits/s
// DATA_BITS    8          data bits per frame (5..9)
// PARITY_BIT   1          1 = append even-parity bit, 0 = no parity bit
// STOP_BITS    2          stop bits per frame (1 or 2)
// PORTS
// SysClk          input   1          system clock, all logic on posedge
// Rst             input   1          synchronous, active-high reset
// Tx_Data         input   DATA_BITS  word to transmit, sampled at frame acceptance
// Transmit_Start  input   1          level request to send Tx_Data
// CTS             input   1          1 = far end clear to send
// Tx              output  1          serial line, idle high
// Tx_Busy         output  1          1 while a frame is in flight
// BEHAVIOUR
// - BAUD_DIV = SYSCLK_RATE/BAUD_RATE (integer, truncating); every bit lasts exactly
//   BAUD_DIV SysClk cycles. Baud counter width $clog2(BAUD_DIV); counter runs only when busy.
// - Reset (Rst=1 at posedge): Tx=1, Tx_Busy=0, state IDLE, counters/shift reg cleared.
//   Reset mid-frame aborts the frame: Tx returns high on that same edge, no partial stop.
// - FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY_BIT=0) -> STOP -> IDLE.
// - IDLE: Tx=1, Tx_Busy=0. At a posedge with Transmit_Start=1 and CTS=1, Tx_Data is
//   latched into shift reg, parity computed (^Tx_Data), state -> START; from that edge
//   Tx=0 and Tx_Busy=1 (registered, zero extra cycles latency).
// - START: Tx=0 for BAUD_DIV cycles -> DATA.
// - DATA: bit index 0..DATA_BITS-1, Tx = shift[0], shift right each bit period; after
//   bit DATA_BITS-1 -> PARITY or STOP.
// - PARITY: Tx = XOR of latched word (even parity: total ones incl. parity is even).
// - STOP: Tx=1 for STOP_BITS*BAUD_DIV cycles -> IDLE; Tx_Busy falls on the same edge.
// - Frame length = (1+DATA_BITS+PARITY_BIT+STOP_BITS)*BAUD_DIV cycles, start to IDLE.
// - IDLE lasts >= 1 cycle between frames (Tx_Busy low >= 1 cycle). Transmit_Start is
//   level-sensitive: if still high with CTS=1 in that IDLE cycle, next frame starts
//   on the following edge. Writer deasserts Transmit_Start once Tx falls.
// - CTS checked only in IDLE; CTS=0 holds request pending (Tx_Busy stays 0). CTS drop
//   mid-frame does not abort or stall the frame.
// - Tx_Data and Transmit_Start changes during a frame are ignored.
// - Tx is driven from a flop, glitch-free; no combinational path input -> Tx.
// TESTING (sim params SYSCLK_RATE=16, BAUD_RATE=1 -> BAUD_DIV=16, DATA_BITS=8)
// 1 Rst high 3 cycles mid-frame -> Tx=1, Tx_Busy=0 on first reset edge; stays idle after.
// 2 Tx_Data=8'hA5, start, CTS=1 -> Tx 0,1,0,1,0,0,1,0,1,par 0,1,1; each bit 16 cycles;
//   Tx_Busy high exactly 192 cycles.
// 3 Tx_Data=8'h07 -> parity bit 1; PARITY_BIT=0 build -> 11-bit frame, 176 cycles.
// 4 CTS=0 with Transmit_Start=1 for 50 cycles -> Tx=1, Tx_Busy=0; CTS->1 -> start
//   bit on next edge. CTS->0 mid-frame -> frame completes unchanged.
// 5 Transmit_Start held high, Tx_Data changed to 8'h3C mid-frame -> first frame unchanged,
//   Tx_Busy low exactly 1 cycle, second frame carries 8'h3C.
// 6 STOP_BITS=1 build, 8'hFF -> stop high 16 cycles, frame 176 cycles total.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialising transmit half of the UART.
// Accepts a parallel word on Tx_Data/Transmit_Start (gated by CTS) and shifts
// it out on Tx as start bit, data bits LSB first, optional even parity and
// one or two stop bits. Every bit lasts SYSCLK_RATE/BAUD_RATE SysClk cycles.
module uart_transmitter #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy
);

    // Bit period in SysClk cycles (truncating divide).
    localparam int BAUD_DIV = SYSCLK_RATE / BAUD_RATE;
    // A divide of 1 still needs a one-bit counter to stay a legal vector.
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic                 bit_end;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;

    // Last cycle of the current bit period.
    always_comb begin
        bit_end = (baud_cnt == BAUD_LAST);
    end

    // Frame sequencer: baud counting, shifting and the registered Tx/Tx_Busy.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            state    <= IDLE;
            Tx       <= 1'b1;
            Tx_Busy  <= 1'b0;
            baud_cnt <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            // Baud counter free-runs over every bit period while a frame is in flight.
            if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    Tx       <= 1'b1;
                    Tx_Busy  <= 1'b0;
                    baud_cnt <= '0;
                    if (Transmit_Start && CTS) begin
                        shift    <= Tx_Data;
                        parity   <= ^Tx_Data;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        state    <= START;
                        Tx       <= 1'b0;
                        Tx_Busy  <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        Tx    <= shift[0];
                        shift <= shift >> 1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY_BIT != 0) begin
                                state <= PARITY;
                                Tx    <= parity;
                            end else begin
                                state <= STOP;
                                Tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            Tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        Tx    <= 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            state   <= IDLE;
                            Tx_Busy <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    Tx      <= 1'b1;
                    Tx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: three builds of the transmitter (parity + 2 stop,
// no parity + 2 stop, parity + 1 stop) driven in parallel and compared cycle
// by cycle against a frame model built from the line-format rules.
module tb_uart_transmitter;

    localparam int BD = 16;

    logic       SysClk = 1'b0;
    logic       Rst;
    logic [7:0] Tx_Data;
    logic       Transmit_Start;
    logic       CTS;
    logic       tx   [3];
    logic       busy [3];

    int vectors    = 0;
    int miscompares = 0;

    // Per-instance build configuration.
    int par_cfg [3] = '{1, 0, 1};
    int stp_cfg [3] = '{2, 2, 1};

    always #5 SysClk = ~SysClk;

    uart_transmitter #(.SYSCLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8),
                       .PARITY_BIT(1), .STOP_BITS(2)) dut_p1s2 (
        .SysClk(SysClk), .Rst(Rst), .Tx_Data(Tx_Data),
        .Transmit_Start(Transmit_Start), .CTS(CTS),
        .Tx(tx[0]), .Tx_Busy(busy[0]));

    uart_transmitter #(.SYSCLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8),
                       .PARITY_BIT(0), .STOP_BITS(2)) dut_p0s2 (
        .SysClk(SysClk), .Rst(Rst), .Tx_Data(Tx_Data),
        .Transmit_Start(Transmit_Start), .CTS(CTS),
        .Tx(tx[1]), .Tx_Busy(busy[1]));

    uart_transmitter #(.SYSCLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8),
                       .PARITY_BIT(1), .STOP_BITS(1)) dut_p1s1 (
        .SysClk(SysClk), .Rst(Rst), .Tx_Data(Tx_Data),
        .Transmit_Start(Transmit_Start), .CTS(CTS),
        .Tx(tx[2]), .Tx_Busy(busy[2]));

    // Line level for bit slot idx of a frame; slots past the frame are idle high.
    function automatic logic frame_bit(int par, int stp, logic [7:0] d, int idx);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par != 0) q.push_back(($countones(d) % 2) == 1);
        for (int i = 0; i < stp; i++) q.push_back(1'b1);
        if (idx < q.size()) return q[idx];
        return 1'b1;
    endfunction

    function automatic int frame_len(int inst);
        return (1 + 8 + par_cfg[inst] + stp_cfg[inst]) * BD;
    endfunction

    // Check every instance shows idle line and not busy.
    task automatic check_idle(string name);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (tx[i] !== 1'b1 || busy[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s inst%0d: tx=%b busy=%b, required tx=1 busy=0",
                         name, i, tx[i], busy[i]);
            end
        end
    endtask

    // Launch a frame (optionally back-to-back with d2) and check all instances
    // cycle by cycle. Sample k is taken at the negedge after the k-th edge
    // following acceptance.
    task automatic run_frame(string name, logic [7:0] d1, bit b2b, logic [7:0] d2,
                             int cts_drop_at);
        int last;
        logic exp_tx, exp_busy;
        int l;
        last = b2b ? 2 * frame_len(0) + 4 : frame_len(0) + 4;
        Tx_Data        = d1;
        Transmit_Start = 1'b1;
        CTS            = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(negedge SysClk);
            for (int i = 0; i < 3; i++) begin
                l = frame_len(i);
                if (k < l) begin
                    exp_tx = frame_bit(par_cfg[i], stp_cfg[i], d1, k / BD);
                    exp_busy = 1'b1;
                end else if (b2b && k > l && k <= 2 * l) begin
                    exp_tx = frame_bit(par_cfg[i], stp_cfg[i], d2, (k - l - 1) / BD);
                    exp_busy = 1'b1;
                end else begin
                    exp_tx = 1'b1;
                    exp_busy = 1'b0;
                end
                vectors++;
                if (tx[i] !== exp_tx || busy[i] !== exp_busy) begin
                    miscompares++;
                    $display("FAIL %s inst%0d cyc%0d: tx=%b busy=%b, required tx=%b busy=%b",
                             name, i, k, tx[i], busy[i], exp_tx, exp_busy);
                end
            end
            if (b2b) begin
                if (k == 0) Tx_Data = d2;
                if (k == frame_len(0) + 1) Transmit_Start = 1'b0;
            end else if (k == 0) begin
                Transmit_Start = 1'b0;
                Tx_Data = 8'($urandom);
            end
            if (k == cts_drop_at) CTS = 1'b0;
        end
        CTS = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Transmit_Start = 1'b0;
        CTS = 1'b1;
        Tx_Data = '0;
        repeat (3) @(negedge SysClk);
        check_idle("reset_state");
        Rst = 1'b0;
        @(negedge SysClk);
        check_idle("post_reset_idle");
        // Abort a frame mid-flight.
        Tx_Data = 8'h00;
        Transmit_Start = 1'b1;
        repeat (40) begin
            @(negedge SysClk);
            Transmit_Start = 1'b0;
        end
        Rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge SysClk);
            check_idle("reset_midframe");
        end
        Rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge SysClk);
            check_idle("idle_after_reset");
        end
    endtask

    task automatic test_frames();
        run_frame("frame_A5", 8'hA5, 1'b0, 8'h00, -1);
        run_frame("frame_07", 8'h07, 1'b0, 8'h00, -1);
        run_frame("frame_FF", 8'hFF, 1'b0, 8'h00, -1);
        run_frame("frame_00", 8'h00, 1'b0, 8'h00, -1);
        for (int r = 0; r < 6; r++) begin
            run_frame("frame_rand", 8'($urandom), 1'b0, 8'h00, -1);
        end
    endtask

    task automatic test_cts();
        Tx_Data = 8'h5A;
        Transmit_Start = 1'b1;
        CTS = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge SysClk);
            check_idle("cts_hold");
        end
        run_frame("cts_release", 8'h5A, 1'b0, 8'h00, -1);
        run_frame("cts_drop_midframe", 8'($urandom), 1'b0, 8'h00, 50);
    endtask

    task automatic test_back_to_back();
        run_frame("back_to_back", 8'hA5, 1'b1, 8'h3C, -1);
        run_frame("back_to_back_rand", 8'($urandom), 1'b1, 8'($urandom), -1);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_cts();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
